// File: rtl/qspi_rx_ctrl.sv
// qspi_rx_ctrl: sequences one QSPI receive burst for the downstream shift
// register. It skips the dummy SCK edges, counts the nibbles in each word,
// flags every completed word and then flags the end of the burst.
//
// Optional build macro: QSPI_RX_TIMEOUT_EN adds an idle-SCK watchdog that
// aborts a stalled transfer and pulses err_o. Without it, err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   start_i, abort_i   start a transaction (accepted only in IDLE), synchronous abort
//   order_i, dummy_i,
//   nibbles_i, words_i transaction configuration, captured when start_i is accepted
//   sck_rise_i         one-cycle sample-edge strobe from the SCK generator
//   valid_o            shift enable; combinational from sck_rise_i while in SHIFT
//   lsb_o, msb_o       shift-mode selects, registered and held for the whole transaction
//   busy_o             high in every state except IDLE
//   word_done_o        shift register holds a complete word this cycle
//   done_o             burst complete
//   nib_cnt_o          nibbles received so far in the current word
//   err_o              idle-SCK timeout pulse
module qspi_rx_ctrl #(
  parameter int unsigned MAX_DUMMY      = 31,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned DUMMY_W = $clog2(MAX_DUMMY + 1),
  localparam int unsigned WORD_W  = $clog2(MAX_WORDS),
  localparam int unsigned NIB_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               order_i,
  input  logic [DUMMY_W-1:0] dummy_i,
  input  logic [NIB_W-1:0]   nibbles_i,
  input  logic [WORD_W-1:0]  words_i,
  input  logic               sck_rise_i,
  output logic               valid_o,
  output logic               lsb_o,
  output logic               msb_o,
  output logic               busy_o,
  output logic               word_done_o,
  output logic               done_o,
  output logic [NIB_W-1:0]   nib_cnt_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DUMMY = 3'd1,
    SHIFT = 3'd2,
    WORD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               order_q, order_d;
  logic [NIB_W-1:0]   nibbles_q, nibbles_d;
  logic [WORD_W-1:0]  words_q, words_d;
  logic [DUMMY_W-1:0] dummy_q, dummy_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               valid_c;
  logic               lsb_q, msb_q, busy_q, word_done_q, done_q;

`ifdef QSPI_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Next-state, counter and shift-enable logic
  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    nibbles_d = nibbles_q;
    words_d   = words_q;
    dummy_d   = dummy_q;
    nib_d     = nib_q;
    word_d    = word_q;
    valid_c   = 1'b0;
`ifdef QSPI_RX_TIMEOUT_EN
    tmo_d     = '0;
    err_d     = 1'b0;
`endif

    if (abort_i) begin
      state_d = IDLE;
      dummy_d = '0;
      nib_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            order_d   = order_i;
            nibbles_d = nibbles_i;
            words_d   = words_i;
            dummy_d   = dummy_i;
            nib_d     = '0;
            word_d    = '0;
            state_d   = (dummy_i != '0) ? DUMMY : SHIFT;
          end
        end
        DUMMY: begin
          if (sck_rise_i) begin
            dummy_d = dummy_q - DUMMY_W'(1);
            if (dummy_q == DUMMY_W'(1)) state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sck_rise_i) begin
            valid_c = 1'b1;
            // Last nibble: hold the count so it never wraps; WORD clears it
            if (nib_q == nibbles_q) state_d = WORD;
            else                    nib_d   = nib_q + NIB_W'(1);
          end
        end
        WORD: begin
          // Any strobe here is dropped; the generator spaces strobes >= 2 cycles
          nib_d = '0;
          if (word_q == words_q) begin
            state_d = DONE;
          end else begin
            word_d  = word_q + WORD_W'(1);
            state_d = SHIFT;
          end
        end
        DONE: begin
          word_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef QSPI_RX_TIMEOUT_EN
    // Idle-SCK watchdog: counts clk_i cycles since the last strobe or state entry
    if (!abort_i && !sck_rise_i && (state_q == DUMMY || state_q == SHIFT)) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        tmo_d   = '0;
        dummy_d = '0;
        nib_d   = '0;
        word_d  = '0;
      end
    end
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      order_q     <= 1'b0;
      nibbles_q   <= '0;
      words_q     <= '0;
      dummy_q     <= '0;
      nib_q       <= '0;
      word_q      <= '0;
      lsb_q       <= 1'b0;
      msb_q       <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      order_q     <= order_d;
      nibbles_q   <= nibbles_d;
      words_q     <= words_d;
      dummy_q     <= dummy_d;
      nib_q       <= nib_d;
      word_q      <= word_d;
      lsb_q       <= (state_d != IDLE) && order_d;
      msb_q       <= (state_d != IDLE) && !order_d;
      busy_q      <= (state_d != IDLE);
      word_done_q <= (state_d == WORD);
      done_q      <= (state_d == DONE);
    end
  end

`ifdef QSPI_RX_TIMEOUT_EN
  // Watchdog counter and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // No watchdog: the parameter is only referenced so both builds share one interface
  assign err_o = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  assign valid_o     = valid_c;
  assign lsb_o       = lsb_q;
  assign msb_o       = msb_q;
  assign busy_o      = busy_q;
  assign word_done_o = word_done_q;
  assign done_o      = done_q;
  assign nib_cnt_o   = nib_q;

endmodule

// File: doc/qspi_rx_ctrl.md
Name: qspi_rx_ctrl

Overview:
- Sequencing controller placed directly upstream of the QSPI receive shift register.
- Takes a single-cycle sample-edge strobe from the SCK generator and runs each receive transaction through dummy cycles and a nibble count.
- Drives the shift register's valid/lsb/msb controls.
- Signals a per-word capture point and end-of-transfer to the host-side logic that reads the assembled 32-bit word.

Parameters:
- MAX_DUMMY, 31: largest dummy-cycle count accepted; sets the dummy counter width to 5 bits.
- MAX_WORDS, 256: largest burst length in words; sets the word counter width to 8 bits.
- TIMEOUT_CYCLES, 1024: idle-SCK limit in clk_i cycles. Used only when QSPI_RX_TIMEOUT_EN is defined.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle transaction start; ignored unless the state is IDLE
- abort_i  input  1  synchronous abort; returns to IDLE next cycle
- order_i  input  1  1 = LSB-first shift (drive lsb), 0 = MSB insert (drive msb); latched at start
- dummy_i  input  5  dummy SCK edges to skip before data; latched at start
- nibbles_i  input  3  nibbles per word minus 1 (0 = 1 nibble, 7 = 8 nibbles); latched at start
- words_i  input  8  words in the burst minus 1; latched at start
- sck_rise_i  input  1  one-cycle strobe marking a sample edge on qsd
- valid_o  output  1  shift-register enable
- lsb_o  output  1  shift-register LSB-mode select
- msb_o  output  1  shift-register MSB-mode select
- busy_o  output  1  high in any state other than IDLE
- word_done_o  output  1  one-cycle pulse; the shift register holds the complete word
- done_o  output  1  one-cycle pulse at the end of the burst
- nib_cnt_o  output  3  nibbles received in the current word
- err_o  output  1  one-cycle timeout pulse; held 0 when the feature is absent

Behaviour:
- Reset (rst_i high, asynchronous):
  - state = IDLE; all counters = 0.
  - valid_o = 0, lsb_o = 0, msb_o = 0, word_done_o = 0, done_o = 0, busy_o = 0, nib_cnt_o = 0, err_o = 0.
- State IDLE:
  - On start_i: latch order_i, dummy_i, nibbles_i and words_i.
  - Load the dummy counter with dummy_i.
  - Next state is DUMMY if dummy_i != 0, otherwise SHIFT.
- State DUMMY:
  - Each sck_rise_i decrements the dummy counter.
  - On the strobe that takes it from 1 to 0, go to SHIFT.
  - valid_o stays 0 throughout.
- State SHIFT:
  - valid_o = sck_rise_i. This is combinational, so the shift register samples qsd in the same cycle as the strobe.
  - lsb_o = latched order; msb_o = inverse of latched order. Both are registered and stable for the whole transaction, and both are 0 in IDLE.
  - Each strobe increments the nibble counter.
  - When a strobe arrives with the counter equal to the latched nibbles value, go to WORD.
- State WORD (1 cycle):
  - word_done_o = 1. The shift register updated on the previous edge, so its output is the full word in this cycle.
  - Clear the nibble counter.
  - If the word counter equals the latched words value: go to DONE.
  - Otherwise: increment the word counter and return to SHIFT. No dummy cycles between words.
  - A sck_rise_i arriving in WORD is dropped. The SCK generator guarantees at least 2 clk_i cycles between strobes.
- State DONE (1 cycle): done_o = 1, then go to IDLE.
- nib_cnt_o: reflects the nibble counter, 0..7.
- Simultaneous events:
  - abort_i has priority over everything, including sck_rise_i and start_i.
  - On abort: go to IDLE next cycle, clear counters, no word_done_o or done_o pulse.
  - start_i while busy is ignored.
- Counter widths: the dummy, nibble and word counters are sized exactly as the port widths. No wrap is reachable because the exit compare fires first.

Optional Feature:
- QSPI_RX_TIMEOUT_EN defined:
  - A counter clears on every sck_rise_i and on entry to DUMMY or SHIFT, and increments every clk_i cycle in DUMMY or SHIFT.
  - When it reaches TIMEOUT_CYCLES-1: pulse err_o for 1 cycle and go to IDLE with no done_o.
- QSPI_RX_TIMEOUT_EN undefined: no counter is built, err_o is tied 0, and the FSM waits indefinitely for strobes.

Test Plan:
- Reset values: assert rst_i mid-SHIFT with nib_cnt_o = 3 -> all outputs 0 immediately; after release, state is IDLE and busy_o = 0.
- Single word, LSB-first: order_i = 1, dummy_i = 0, nibbles_i = 7, words_i = 0, then 8 strobes spaced 3 cycles apart:
  - valid_o exactly 8 times; lsb_o = 1 and msb_o = 0 throughout.
  - word_done_o 1 cycle after the 8th strobe, then done_o on the next cycle.
- Dummy skip: dummy_i = 4, nibbles_i = 1 -> valid_o stays 0 for the first 4 strobes and is high on strobes 5 and 6; word_done_o follows strobe 6.
- Burst: words_i = 2, nibbles_i = 7 -> three word_done_o pulses after strobes 8, 16 and 24; one done_o; nib_cnt_o returns to 0 after each word.
- Abort and start priority: abort_i together with a strobe at nib_cnt_o = 5 -> no valid_o in that cycle, IDLE next cycle, no done_o; start_i pulsed while busy -> no effect on the latched configuration.
- Timeout: with QSPI_RX_TIMEOUT_EN and TIMEOUT_CYCLES = 16, stop strobes in SHIFT -> err_o pulses 16 cycles after the last strobe, then IDLE; without the macro the controller stays in SHIFT and err_o stays 0.
